// File: rtl/iso7816_t0_pkg.sv
// Shared T=0 definitions: FSM states, error causes, procedure-byte classes.
package iso7816_t0_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned REM_W  = 9;
    localparam int unsigned IDX_W  = 3;

    localparam logic [BYTE_W-1:0] T0_NULL = 8'h60;

    typedef enum logic [2:0] {
        ST_HDR      = 3'd0,
        ST_PROC     = 3'd1,
        ST_DATA_ALL = 3'd2,
        ST_DATA_ONE = 3'd3,
        ST_SW2      = 3'd4
    } t0_state_e;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_BAD_INS     = 2'd1,
        ERR_BAD_PROC    = 2'd2,
        ERR_ACK_OVERRUN = 2'd3
    } t0_err_e;

    typedef enum logic [2:0] {
        PB_NULL    = 3'd0,
        PB_SW1     = 3'd1,
        PB_ACK     = 3'd2,
        PB_NACK    = 3'd3,
        PB_INVALID = 3'd4
    } t0_pb_class_e;

    typedef struct packed {
        logic [BYTE_W-1:0] cla;
        logic [BYTE_W-1:0] ins;
        logic [BYTE_W-1:0] p1;
        logic [BYTE_W-1:0] p2;
        logic [BYTE_W-1:0] p3;
    } t0_hdr_t;

    // 0x6X / 0x9X: status-word range, also illegal as INS
    function automatic logic is_sw_range(input logic [BYTE_W-1:0] b);
        return (b[7:4] == 4'h6) || (b[7:4] == 4'h9);
    endfunction

endpackage

// File: rtl/t0_proc_byte_classifier.sv
// Classifies a T=0 procedure byte against the current INS.
module t0_proc_byte_classifier
    import iso7816_t0_pkg::*;
(
    input  logic [BYTE_W-1:0] pb,
    input  logic [BYTE_W-1:0] ins,
    output t0_pb_class_e      pb_class_c
);

    always_comb begin
        pb_class_c = PB_INVALID;
        if (pb == T0_NULL)
            pb_class_c = PB_NULL;
        else if (is_sw_range(pb))
            pb_class_c = PB_SW1;
        else if (pb == ins)
            pb_class_c = PB_ACK;
        else if (pb == (ins ^ 8'hFF))
            pb_class_c = PB_NACK;
    end

endmodule

// File: rtl/iso7816_3_t0_tpdu_monitor.sv
// Passive T=0 TPDU tracker: header, procedure bytes, data and status word capture,
// plus the expected-direction hint for the analyzer.
module iso7816_3_t0_tpdu_monitor
    import iso7816_t0_pkg::*;
(
    input  logic              isoClk,
    input  logic              nReset,
    input  logic              enable,
    input  logic              byteValid,
    input  logic [BYTE_W-1:0] byteData,
    input  logic              byteError,
    output logic [BYTE_W-1:0] cla,
    output logic [BYTE_W-1:0] ins,
    output logic [BYTE_W-1:0] p1,
    output logic [BYTE_W-1:0] p2,
    output logic [BYTE_W-1:0] p3,
    output logic [BYTE_W-1:0] sw1,
    output logic [BYTE_W-1:0] sw2,
    output logic [REM_W-1:0]  remaining,
    output logic              waitCardTx,
    output logic              waitTermTx,
    output logic              tpduDone,
    output logic              procError,
    output logic [1:0]        errCode,
    output logic [BYTE_W-1:0] nullCnt,
    output logic [2:0]        state
);

    t0_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    t0_hdr_t           hdr_q, hdr_d;
    logic [BYTE_W-1:0] sw1_q, sw1_d, sw2_q, sw2_d;
    logic [REM_W-1:0]  remaining_q, remaining_d;
    logic [BYTE_W-1:0] null_cnt_q, null_cnt_d;
    t0_err_e           err_code_q, err_code_d;
    logic              done_q, done_d;
    logic              proc_err_q, proc_err_d;
    logic              wait_card_q, wait_card_d;
    logic              wait_term_q, wait_term_d;

    t0_pb_class_e      pb_class_c;
    logic              take_c;

    t0_proc_byte_classifier u_classifier (
        .pb         (byteData),
        .ins        (hdr_q.ins),
        .pb_class_c (pb_class_c)
    );

    assign take_c = byteValid && !byteError;

    always_ff @(posedge isoClk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_HDR;
            idx_q       <= '0;
            hdr_q       <= '0;
            sw1_q       <= '0;
            sw2_q       <= '0;
            remaining_q <= '0;
            null_cnt_q  <= '0;
            err_code_q  <= ERR_NONE;
            done_q      <= 1'b0;
            proc_err_q  <= 1'b0;
            wait_card_q <= 1'b0;
            wait_term_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hdr_q       <= hdr_d;
            sw1_q       <= sw1_d;
            sw2_q       <= sw2_d;
            remaining_q <= remaining_d;
            null_cnt_q  <= null_cnt_d;
            err_code_q  <= err_code_d;
            done_q      <= done_d;
            proc_err_q  <= proc_err_d;
            wait_card_q <= wait_card_d;
            wait_term_q <= wait_term_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hdr_d       = hdr_q;
        sw1_d       = sw1_q;
        sw2_d       = sw2_q;
        remaining_d = remaining_q;
        null_cnt_d  = null_cnt_q;
        err_code_d  = err_code_q;
        done_d      = 1'b0;
        proc_err_d  = 1'b0;
        wait_card_d = 1'b0;
        wait_term_d = 1'b0;

        if (!enable) begin
            // disable wins over a coincident byte
            state_d     = ST_HDR;
            idx_d       = '0;
            remaining_d = '0;
            null_cnt_d  = '0;
        end else if (take_c) begin
            unique case (state_q)
                ST_HDR: begin
                    idx_d = idx_q + 3'd1;
                    case (idx_q)
                        3'd0:    hdr_d.cla = byteData;
                        3'd1:    hdr_d.ins = byteData;
                        3'd2:    hdr_d.p1  = byteData;
                        3'd3:    hdr_d.p2  = byteData;
                        default: begin
                            hdr_d.p3    = byteData;
                            idx_d       = '0;
                            remaining_d = (byteData == 8'h00) ? 9'd256 : {1'b0, byteData};
                            null_cnt_d  = '0;
                            state_d     = ST_PROC;
                            if (is_sw_range(hdr_q.ins)) begin
                                proc_err_d = 1'b1;
                                err_code_d = ERR_BAD_INS;
                            end
                        end
                    endcase
                end
                ST_PROC: begin
                    unique case (pb_class_c)
                        PB_NULL: begin
                            if (null_cnt_q != 8'hFF)
                                null_cnt_d = null_cnt_q + 8'd1;
                        end
                        PB_SW1: begin
                            sw1_d   = byteData;
                            state_d = ST_SW2;
                        end
                        PB_ACK, PB_NACK: begin
                            if (remaining_q == '0) begin
                                proc_err_d = 1'b1;
                                err_code_d = ERR_ACK_OVERRUN;
                            end else begin
                                state_d = (pb_class_c == PB_ACK) ? ST_DATA_ALL : ST_DATA_ONE;
                            end
                        end
                        default: begin
                            proc_err_d = 1'b1;
                            err_code_d = ERR_BAD_PROC;
                            idx_d      = '0;
                            state_d    = ST_HDR;
                        end
                    endcase
                end
                ST_DATA_ALL: begin
                    if (remaining_q != '0)
                        remaining_d = remaining_q - 9'd1;
                    if (remaining_q <= 9'd1)
                        state_d = ST_PROC;
                end
                ST_DATA_ONE: begin
                    if (remaining_q != '0)
                        remaining_d = remaining_q - 9'd1;
                    state_d = ST_PROC;
                end
                ST_SW2: begin
                    sw2_d   = byteData;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_HDR;
                end
                default: begin
                    idx_d   = '0;
                    state_d = ST_HDR;
                end
            endcase
        end

        // direction hint follows the state being entered
        if (enable) begin
            unique case (state_d)
                ST_HDR:                   begin wait_card_d = 1'b0; wait_term_d = 1'b1; end
                ST_PROC, ST_SW2:          begin wait_card_d = 1'b1; wait_term_d = 1'b0; end
                ST_DATA_ALL, ST_DATA_ONE: begin wait_card_d = 1'b1; wait_term_d = 1'b1; end
                default:                  begin wait_card_d = 1'b0; wait_term_d = 1'b1; end
            endcase
        end
    end

    assign cla        = hdr_q.cla;
    assign ins        = hdr_q.ins;
    assign p1         = hdr_q.p1;
    assign p2         = hdr_q.p2;
    assign p3         = hdr_q.p3;
    assign sw1        = sw1_q;
    assign sw2        = sw2_q;
    assign remaining  = remaining_q;
    assign waitCardTx = wait_card_q;
    assign waitTermTx = wait_term_q;
    assign tpduDone   = done_q;
    assign procError  = proc_err_q;
    assign errCode    = 2'(err_code_q);
    assign nullCnt    = null_cnt_q;
    assign state      = 3'(state_q);

endmodule

// File: tb/tb_iso7816_3_t0_tpdu_monitor.sv
// Directed bench for the T=0 TPDU monitor with hand-computed expectations.
module tb_iso7816_3_t0_tpdu_monitor;

    logic       isoClk = 1'b0;
    logic       nReset;
    logic       enable;
    logic       byteValid;
    logic [7:0] byteData;
    logic       byteError;
    logic [7:0] cla, ins, p1, p2, p3, sw1, sw2, nullCnt;
    logic [8:0] remaining;
    logic       waitCardTx, waitTermTx, tpduDone, procError;
    logic [1:0] errCode;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    localparam logic [2:0] S_HDR = 3'd0, S_PROC = 3'd1, S_DALL = 3'd2,
                           S_DONE1 = 3'd3, S_SW2 = 3'd4;

    iso7816_3_t0_tpdu_monitor dut (
        .isoClk     (isoClk),
        .nReset     (nReset),
        .enable     (enable),
        .byteValid  (byteValid),
        .byteData   (byteData),
        .byteError  (byteError),
        .cla        (cla),
        .ins        (ins),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .sw1        (sw1),
        .sw2        (sw2),
        .remaining  (remaining),
        .waitCardTx (waitCardTx),
        .waitTermTx (waitTermTx),
        .tpduDone   (tpduDone),
        .procError  (procError),
        .errCode    (errCode),
        .nullCnt    (nullCnt),
        .state      (state)
    );

    always #5 isoClk = ~isoClk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one-cycle byte pulse; returns on the negedge where the result is visible
    task automatic send_byte(input logic [7:0] b, input logic err);
        @(negedge isoClk);
        byteValid = 1'b1;
        byteData  = b;
        byteError = err;
        @(negedge isoClk);
        byteValid = 1'b0;
        byteError = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] c, input logic [7:0] i,
                            input logic [7:0] a, input logic [7:0] b, input logic [7:0] l);
        send_byte(c, 1'b0);
        send_byte(i, 1'b0);
        send_byte(a, 1'b0);
        send_byte(b, 1'b0);
        send_byte(l, 1'b0);
    endtask

    initial begin
        nReset = 1'b0; enable = 1'b0; byteValid = 1'b0; byteData = 8'h00; byteError = 1'b0;
        repeat (3) @(negedge isoClk);
        check_val("rst_state", 32'(state), 32'(S_HDR));
        check_val("rst_waits", {30'd0, waitCardTx, waitTermTx}, 32'd0);
        check_val("rst_remaining", 32'(remaining), 32'd0);
        check_val("rst_err", {29'd0, procError, errCode}, 32'd0);
        check_val("rst_sw", {16'd0, sw1, sw2}, 32'd0);
        nReset = 1'b1;
        @(negedge isoClk);
        enable = 1'b1;
        @(negedge isoClk);
        check_val("en_state", 32'(state), 32'(S_HDR));
        check_val("en_waits", {30'd0, waitCardTx, waitTermTx}, 32'd1);

        // case 2, ACK all-at-once
        send_hdr(8'h00, 8'hB0, 8'h00, 8'h00, 8'h04);
        check_val("c2_hdr_state", 32'(state), 32'(S_PROC));
        check_val("c2_rem_load", 32'(remaining), 32'd4);
        check_val("c2_proc_waits", {30'd0, waitCardTx, waitTermTx}, 32'd2);
        send_byte(8'hB0, 1'b0);
        check_val("c2_dall", 32'(state), 32'(S_DALL));
        check_val("c2_dall_waits", {30'd0, waitCardTx, waitTermTx}, 32'd3);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'(8'h10 + k), 1'b0);
            check_val("c2_rem_dec", 32'(remaining), 32'(3 - k));
        end
        check_val("c2_back_proc", 32'(state), 32'(S_PROC));
        send_byte(8'h90, 1'b0);
        check_val("c2_sw2_state", 32'(state), 32'(S_SW2));
        check_val("c2_sw1", 32'(sw1), 32'h90);
        send_byte(8'h00, 1'b0);
        check_val("c2_done", 32'(tpduDone), 32'd1);
        check_val("c2_sw2", 32'(sw2), 32'h00);
        check_val("c2_end_state", 32'(state), 32'(S_HDR));
        check_val("c2_errcode", {30'd0, errCode}, 32'd0);
        @(negedge isoClk);
        check_val("c2_done_one_cycle", 32'(tpduDone), 32'd0);

        // byte-by-byte NACK with NULLs
        send_hdr(8'h00, 8'hD6, 8'h00, 8'h00, 8'h02);
        send_byte(8'h60, 1'b0);
        send_byte(8'h60, 1'b0);
        check_val("nk_nullcnt", 32'(nullCnt), 32'd2);
        check_val("nk_null_state", 32'(state), 32'(S_PROC));
        send_byte(8'h29, 1'b0);
        check_val("nk_done1_a", 32'(state), 32'(S_DONE1));
        send_byte(8'hAA, 1'b0);
        check_val("nk_rem_a", 32'(remaining), 32'd1);
        check_val("nk_proc_a", 32'(state), 32'(S_PROC));
        send_byte(8'h29, 1'b0);
        check_val("nk_done1_b", 32'(state), 32'(S_DONE1));
        send_byte(8'hBB, 1'b0);
        check_val("nk_rem_b", 32'(remaining), 32'd0);
        send_byte(8'h90, 1'b0);
        send_byte(8'h00, 1'b0);
        check_val("nk_done", 32'(tpduDone), 32'd1);
        check_val("nk_nullcnt_end", 32'(nullCnt), 32'd2);

        // case 1, P3 = 0
        send_hdr(8'h00, 8'hA4, 8'h00, 8'h00, 8'h00);
        check_val("c1_rem256", 32'(remaining), 32'd256);
        check_val("c1_nullclr", 32'(nullCnt), 32'd0);
        send_byte(8'h6A, 1'b0);
        check_val("c1_sw2_state", 32'(state), 32'(S_SW2));
        check_val("c1_sw1", 32'(sw1), 32'h6A);
        send_byte(8'h82, 1'b0);
        check_val("c1_sw2", 32'(sw2), 32'h82);
        check_val("c1_done", 32'(tpduDone), 32'd1);
        check_val("c1_rem_untouched", 32'(remaining), 32'd256);

        // invalid procedure byte, then a fresh header
        send_hdr(8'h00, 8'hB0, 8'h00, 8'h00, 8'h04);
        send_byte(8'h12, 1'b0);
        check_val("inv_perr", 32'(procError), 32'd1);
        check_val("inv_code", {30'd0, errCode}, 32'd2);
        check_val("inv_state", 32'(state), 32'(S_HDR));
        send_hdr(8'h00, 8'hC0, 8'h00, 8'h00, 8'h10);
        check_val("inv_new_ins", 32'(ins), 32'hC0);
        check_val("inv_new_rem", 32'(remaining), 32'd16);
        check_val("inv_new_state", 32'(state), 32'(S_PROC));
        check_val("inv_code_held", {30'd0, errCode}, 32'd2);
        send_byte(8'h90, 1'b0);
        send_byte(8'h00, 1'b0);

        // parity errors on header bytes are ignored
        send_byte(8'h80, 1'b1);
        check_val("par_cla_hold", 32'(cla), 32'h00);
        send_byte(8'h80, 1'b0);
        send_byte(8'hCA, 1'b1);
        send_byte(8'hCA, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        check_val("par_hdr", {cla, ins, p1, p2}, 32'h80CA0102);
        check_val("par_p3", 32'(p3), 32'h03);
        check_val("par_state", 32'(state), 32'(S_PROC));

        // disable mid-data with a coincident byte
        send_byte(8'hCA, 1'b0);
        check_val("dis_pre_rem", 32'(remaining), 32'd3);
        @(negedge isoClk);
        enable = 1'b0; byteValid = 1'b1; byteData = 8'h55;
        @(negedge isoClk);
        byteValid = 1'b0;
        check_val("dis_state", 32'(state), 32'(S_HDR));
        check_val("dis_rem", 32'(remaining), 32'd0);
        check_val("dis_waits", {30'd0, waitCardTx, waitTermTx}, 32'd0);
        check_val("dis_keep", {cla, ins, sw1, sw2}, 32'h80CA9000);
        enable = 1'b1;
        @(negedge isoClk);
        check_val("reen_waits", {30'd0, waitCardTx, waitTermTx}, 32'd1);

        // illegal INS still proceeds to PROC
        send_hdr(8'h00, 8'h65, 8'h00, 8'h00, 8'h01);
        check_val("bins_perr", 32'(procError), 32'd1);
        check_val("bins_code", {30'd0, errCode}, 32'd1);
        check_val("bins_state", 32'(state), 32'(S_PROC));
        send_byte(8'h90, 1'b0);
        send_byte(8'h00, 1'b0);

        // ACK overrun and NULL saturation
        send_hdr(8'h00, 8'hB0, 8'h00, 8'h00, 8'h01);
        check_val("ovr_no_perr", 32'(procError), 32'd0);
        send_byte(8'hB0, 1'b0);
        send_byte(8'h77, 1'b0);
        check_val("ovr_proc", 32'(state), 32'(S_PROC));
        send_byte(8'hB0, 1'b0);
        check_val("ovr_perr", 32'(procError), 32'd1);
        check_val("ovr_code", {30'd0, errCode}, 32'd3);
        check_val("ovr_state", 32'(state), 32'(S_PROC));
        for (int k = 0; k < 260; k++) send_byte(8'h60, 1'b0);
        check_val("null_sat", 32'(nullCnt), 32'd255);
        send_byte(8'h90, 1'b0);
        send_byte(8'h00, 1'b0);
        check_val("ovr_done", 32'(tpduDone), 32'd1);

        // asynchronous reset mid-TPDU
        send_hdr(8'h00, 8'hB0, 8'h00, 8'h00, 8'h08);
        #2 nReset = 1'b0;
        #1;
        check_val("arst_state", 32'(state), 32'(S_HDR));
        check_val("arst_rem", 32'(remaining), 32'd0);
        check_val("arst_ins", 32'(ins), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
